// File: rtl/envelope_vca.sv
// Envelope-controlled amplifier: scales signed samples by an unsigned envelope
// level through a two-stage multiply / round-saturate pipeline with a peak meter.
module envelope_vca #(
  parameter int DW        = 16,
  parameter int EW        = 18,
  parameter int ENV_SHIFT = 7
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EW-1:0]        env_value,
  input  logic                 env_busy,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        peak_abs,
  output logic                 clip,
  input  logic                 peak_clr
);

  localparam int PW = DW + EW + 1;

  localparam logic signed [PW-1:0] RND  = {{(PW-ENV_SHIFT){1'b0}}, 1'b1, {(ENV_SHIFT-1){1'b0}}};
  localparam logic signed [PW-1:0] MAXV = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAX_DW = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_DW = {1'b1, {(DW-1){1'b0}}};

  // Handshake: a word moves on valid & ready in the same cycle. The whole
  // pipeline advances when the output register is empty or being drained;
  // in_ready depends only on out_valid/out_ready, never on in_valid.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] s1_prod;
  logic                 s1_valid;
  logic signed [PW-1:0] r_full;
  logic signed [DW-1:0] r_sat;
  logic                 s1_sat;
  logic                 out_sat;
  logic [DW-1:0]        a_abs;
  logic                 xfer;

  always_comb begin
    prod = '0;
    if (env_busy)
      prod = $signed(in_data) * $signed({1'b0, env_value});
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_prod  <= '0;
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_prod  <= prod;
      s1_valid <= in_valid;
    end
  end

  // Round half up, then clamp to the signed output range.
  always_comb begin
    r_full = (s1_prod + RND) >>> ENV_SHIFT;
    r_sat  = r_full[DW-1:0];
    s1_sat = 1'b0;
    if (r_full > MAXV) begin
      r_sat  = MAX_DW;
      s1_sat = 1'b1;
    end else if (r_full < MINV) begin
      r_sat  = MIN_DW;
      s1_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= r_sat;
        out_sat  <= s1_sat;
      end
    end
  end

  assign xfer = out_valid & out_ready;

  always_comb begin
    if (out_data == MIN_DW)
      a_abs = MAX_DW;
    else if (out_data[DW-1])
      a_abs = DW'(-out_data);
    else
      a_abs = out_data;
  end

  // A transfer in the same cycle as a clear restarts the meter from that sample.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      peak_abs <= '0;
      clip     <= 1'b0;
    end else if (peak_clr) begin
      peak_abs <= xfer ? a_abs : '0;
      clip     <= xfer ? out_sat : 1'b0;
    end else if (xfer) begin
      if (a_abs > peak_abs)
        peak_abs <= a_abs;
      if (out_sat)
        clip <= 1'b1;
    end
  end

endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca: vector table for arithmetic and meter,
// plus hand sequences for backpressure, clear-with-transfer and reset.
module tb_envelope_vca;

  logic               clk;
  logic               rst_b;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [17:0]        env_value;
  logic               env_busy;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        peak_abs;
  logic               clip;
  logic               peak_clr;

  int n_checks = 0;
  int n_errors = 0;

  envelope_vca #(.DW(16), .EW(18), .ENV_SHIFT(7)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .env_value(env_value), .env_busy(env_busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .peak_abs(peak_abs), .clip(clip), .peak_clr(peak_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic signed [15:0] din;
    logic [17:0]        env;
    logic               busy;
    logic               clr;
    logic signed [15:0] exp_out;
    logic [15:0]        exp_peak;
    logic               exp_clip;
  } vec_t;

  vec_t vec[13];

  // Scoreboard for the streaming sequence.
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("stream_extra", $signed(out_data), -1);
      end else begin
        check("stream_data", $signed(out_data), $signed(exp_q.pop_front()));
      end
    end
  end

  // Single isolated sample with out_ready=1: checks latency, value, meter.
  task automatic send_one(input string name, input logic signed [15:0] d,
                          input logic [17:0] e, input logic b,
                          input logic signed [15:0] exp_out,
                          input logic [15:0] exp_peak, input logic exp_clip);
    in_data = d; env_value = e; env_busy = b; in_valid = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    env_value = 18'h3ffff; env_busy = ~b; in_data = ~d;
    check({name, "_valid_n1"}, out_valid, 0);
    @(posedge clk); #1;
    check({name, "_valid_n2"}, out_valid, 1);
    check({name, "_data"}, $signed(out_data), exp_out);
    @(posedge clk); #1;
    check({name, "_peak"}, peak_abs, exp_peak);
    check({name, "_clip"}, clip, exp_clip);
  endtask

  task automatic pulse_clr();
    peak_clr = 1'b1;
    @(posedge clk); #1;
    peak_clr = 1'b0;
  endtask

  task automatic stream_sample(input logic [15:0] v);
    int budget;
    logic r;
    in_data = v; env_value = 18'd128; env_busy = 1'b1; in_valid = 1'b1;
    budget = 50;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      budget--;
    end while (!r && budget > 0);
    if (!r) check("stream_accept_timeout", 0, 1);
    else exp_q.push_back(v);
    in_valid = 1'b0;
  endtask

  initial begin
    logic signed [15:0] held;
    int budget;

    vec[0]  = '{16'sd1000,  18'd64,     1'b1, 1'b0, 16'sd500,   16'd500,   1'b0};
    vec[1]  = '{16'sd3,     18'd64,     1'b1, 1'b0, 16'sd2,     16'd500,   1'b0};
    vec[2]  = '{-16'sd3,    18'd64,     1'b1, 1'b0, -16'sd1,    16'd500,   1'b0};
    vec[3]  = '{16'sd100,   18'd128,    1'b1, 1'b0, 16'sd100,   16'd500,   1'b0};
    vec[4]  = '{16'h8000,   18'd255,    1'b1, 1'b0, 16'h8000,   16'd32767, 1'b1};
    vec[5]  = '{16'sd20000, 18'd1000,   1'b1, 1'b0, 16'sd32767, 16'd32767, 1'b1};
    vec[6]  = '{16'sd12345, 18'd200,    1'b0, 1'b0, 16'sd0,     16'd32767, 1'b1};
    vec[7]  = '{-16'sd1000, 18'd128,    1'b1, 1'b1, -16'sd1000, 16'd1000,  1'b0};
    vec[8]  = '{16'sd300,   18'd0,      1'b1, 1'b0, 16'sd0,     16'd1000,  1'b0};
    vec[9]  = '{-16'sd7,    18'd200,    1'b1, 1'b0, -16'sd11,   16'd1000,  1'b0};
    vec[10] = '{16'sd255,   18'd1,      1'b1, 1'b0, 16'sd2,     16'd1000,  1'b0};
    vec[11] = '{-16'sd1,    18'd64,     1'b1, 1'b0, 16'sd0,     16'd1000,  1'b0};
    vec[12] = '{16'sd32767, 18'd262143, 1'b1, 1'b0, 16'sd32767, 16'd32767, 1'b1};

    rst_b = 1'b0; in_data = '0; in_valid = 1'b0; env_value = '0; env_busy = 1'b0;
    out_ready = 1'b1; peak_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_peak", peak_abs, 0);
    check("rst_clip", clip, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      if (vec[i].clr) begin
        pulse_clr();
        check($sformatf("v%0d_clr_peak", i), peak_abs, 0);
        check($sformatf("v%0d_clr_clip", i), clip, 0);
      end
      send_one($sformatf("v%0d", i), vec[i].din, vec[i].env, vec[i].busy,
               vec[i].exp_out, vec[i].exp_peak, vec[i].exp_clip);
    end

    // Clear coinciding with a transfer: the transferred sample wins.
    in_data = 16'sd5; env_value = 18'd128; env_busy = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("clrx_valid", out_valid, 1);
    peak_clr = 1'b1;
    @(posedge clk); #1;
    peak_clr = 1'b0;
    check("clrx_peak", peak_abs, 5);
    check("clrx_clip", clip, 0);

    // Streaming 1..10 with a 3-cycle stall in the middle.
    mon_en = 1'b1;
    fork
      begin
        for (int v = 1; v <= 10; v++) stream_sample(16'(v));
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        check("stall_valid", out_valid, 1);
        out_ready = 1'b0;
        held = out_data;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_data_hold", $signed(out_data), held);
          check("stall_valid_hold", out_valid, 1);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
      end
    join
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); budget--;
    end
    check("stream_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    check("stream_peak", peak_abs, 10);

    // Reset with two samples in flight.
    in_data = 16'sd111; env_value = 18'd128; env_busy = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 16'sd222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_peak", peak_abs, 0);
    check("mrst_clip", clip, 0);
    @(negedge clk); rst_b = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("mrst_no_stale", out_valid, 0);
    end
    send_one("post_rst", 16'sd77, 18'd128, 1'b1, 16'sd77, 16'd77, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
